// File: rtl/mem_access_unit.sv
// mem_access_unit -- data-memory access stage of the pipeline.
//
// Accepts one load/store from the EX/MEM slot, runs it on a simple
// request/acknowledge bus and returns extended load data with a one-cycle
// completion pulse. Upstream is frozen with mem_stall while an access is
// being accepted or is outstanding on the bus.
//
// Configuration macro: MEM_MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses never reach the bus; they
//               complete next cycle with mem_misalign=1 and mem_rdo=0.
//   undefined : mem_misalign is tied low and the offending low address
//               bits are cleared so the access proceeds aligned.
//
// Ports
//   clk, rst           : clock (rising edge), asynchronous active-high reset
//   ex_valid           : EX/MEM slot holds a valid instruction
//   ex_alu_c           : byte address
//   ex_wdata           : store data (right-justified)
//   ex_dram_we/re      : store / load request (both set = store)
//   ex_size            : 00 byte, 01 half, 1x word
//   ex_unsigned        : zero-extend load result
//   mem_stall          : freeze upstream stages
//   bus_req/we/addr/wdata/be : bus request, held constant until bus_ack
//   bus_ack, bus_rdata : one-cycle completion, read data valid with ack
//   mem_rdo            : extended load data
//   mem_valid          : completion pulse
//   mem_misalign       : alignment fault pulse
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_c,
  input  logic [31:0] ex_wdata,
  input  logic        ex_dram_we,
  input  logic        ex_dram_re,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  output logic        mem_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] mem_rdo,
  output logic        mem_valid,
  output logic        mem_misalign
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg;

  // Captured access attributes needed when the read data comes back.
  logic [1:0]  addr_lo_reg;
  logic [1:0]  size_reg;
  logic        unsigned_reg;
  logic        we_reg;

  logic        accept;
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        fault;
  logic [31:0] addr_next;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [7:0]  rd_lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  // A new access can only be taken when nothing is outstanding on the bus.
  assign accept  = ex_valid & (ex_dram_re | ex_dram_we) & (state_reg != BUSY);
  assign is_byte = (ex_size == 2'b00);
  assign is_half = (ex_size == 2'b01);
  assign is_word = ex_size[1];

  // Gated by rst so the stall drops the instant reset is applied, even if
  // the slot still presents a request.
  assign mem_stall = ~rst & (accept | (state_reg == BUSY));

  // Natural alignment of the request. With the trap enabled, misaligned
  // accesses never use this address, so the clearing is harmless there.
  always_comb begin
    addr_next = ex_alu_c;
    if (is_word) begin
      addr_next[1:0] = 2'b00;
    end else if (is_half) begin
      addr_next[0] = 1'b0;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign fault = (is_half & ex_alu_c[0]) | (is_word & (ex_alu_c[1:0] != 2'b00));
`else
  assign fault        = 1'b0;
  assign mem_misalign = 1'b0;
`endif

  // Byte enables and lane-replicated store data for the aligned request.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = ex_wdata;
    if (is_byte) begin
      be_next    = 4'b0001 << addr_next[1:0];
      wdata_next = {4{ex_wdata[7:0]}};
    end else if (is_half) begin
      be_next    = addr_next[1] ? 4'b1100 : 4'b0011;
      wdata_next = {2{ex_wdata[15:0]}};
    end
  end

  // Split the returned word into byte lanes for lane selection.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
    assign rd_lane[gi] = bus_rdata[8*gi +: 8];
  end

  assign byte_sel = rd_lane[addr_lo_reg];
  assign half_sel = addr_lo_reg[1] ? {rd_lane[3], rd_lane[2]} : {rd_lane[1], rd_lane[0]};

  always_comb begin
    load_ext = bus_rdata;
    case (size_reg)
      2'b00:   load_ext = {{24{~unsigned_reg & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{~unsigned_reg & half_sel[15]}}, half_sel};
      default: load_ext = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      addr_lo_reg  <= 2'b00;
      size_reg     <= 2'b00;
      unsigned_reg <= 1'b0;
      we_reg       <= 1'b0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= 32'h0;
      bus_wdata    <= 32'h0;
      bus_be       <= 4'b0000;
      mem_rdo      <= 32'h0;
      mem_valid    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mem_misalign <= 1'b0;
`endif
    end else begin
      mem_valid <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mem_misalign <= 1'b0;
`endif
      case (state_reg)
        BUSY: begin
          // Request stays frozen until the acknowledge is seen.
          if (bus_ack) begin
            state_reg <= DONE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_be    <= 4'b0000;
            mem_valid <= 1'b1;
            if (!we_reg) begin
              mem_rdo <= load_ext;
            end
          end
        end
        default: begin
          // IDLE and DONE both accept; DONE falls back to IDLE otherwise.
          if (accept) begin
            addr_lo_reg  <= addr_next[1:0];
            size_reg     <= ex_size;
            unsigned_reg <= ex_unsigned;
            we_reg       <= ex_dram_we;
            if (fault) begin
              // Faulting access skips the bus and completes immediately.
              state_reg <= DONE;
              mem_valid <= 1'b1;
              mem_rdo   <= 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
              mem_misalign <= 1'b1;
`endif
            end else begin
              state_reg <= BUSY;
              bus_req   <= 1'b1;
              bus_we    <= ex_dram_we;
              bus_addr  <= {addr_next[31:2], 2'b00};
              bus_wdata <= wdata_next;
              bus_be    <= be_next;
            end
          end else begin
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
